// File: rtl/tans_pkg.sv
// Shared types and widths for the tANS recoder controller: FSM states,
// output FIFO entry layout and the recoder result masking helper.
package tans_pkg;

  localparam int STATE_W = 4;
  localparam int BITS_W  = 3;
  localparam int LEN_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } tans_state_e;

  typedef struct packed {
    logic [BITS_W-1:0] bits;
    logic [LEN_W-1:0]  len;
  } ofifo_entry_t;

  // Keep only the low 'len' bits of the recoder's o_stream word.
  function automatic logic [BITS_W-1:0] mask_bits(input logic [BITS_W-1:0] ostream,
                                                  input logic [LEN_W-1:0]  len);
    logic [BITS_W-1:0] m;
    m = '0;
    for (int i = 0; i < BITS_W; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return ostream & m;
  endfunction

endpackage

// File: rtl/tans_ofifo.sv
// Output FIFO of {bits, len} entries with an occupancy count; pointers wrap
// modulo DEPTH so any depth >= 2 is legal.
module tans_ofifo
  import tans_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       PHI,
  input  logic                       RST_N,
  input  logic                       push,
  input  ofifo_entry_t               push_data,
  input  logic                       pop,
  output ofifo_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  ofifo_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge PHI) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge PHI or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The controller's credit scheme must never let a push land on a full FIFO.
  assert property (@(posedge PHI) disable iff (!RST_N) push |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/tans_recoder_ctrl.sv
// Feeds Huffman bits into a fixed-latency tANS recoder, collects non-empty
// results into an output FIFO and reports the final state per message.
module tans_recoder_ctrl
  import tans_pkg::*;
#(
  parameter int PIPE_LAT    = 3,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic               PHI,
  input  logic               RST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  input  logic               in_last,
  output logic               rec_bit,
  output logic               rec_if,
  input  logic [LEN_W-1:0]   rec_btr,
  input  logic [BITS_W-1:0]  rec_ostream,
  input  logic [STATE_W-1:0] rec_final,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS_W-1:0]  out_bits,
  output logic [LEN_W-1:0]   out_len,
  output logic               msg_done,
  output logic [STATE_W-1:0] msg_state,
  output logic [1:0]         fsm_state
);

  // Handshakes: a transfer happens on a rising PHI edge where valid && ready;
  // ready never depends on valid, and the sender holds data while valid && !ready.

  localparam int CW = $clog2(OFIFO_DEPTH + 1);
  localparam int IW = $clog2(PIPE_LAT + 1);

  tans_state_e         state, state_nxt;
  logic                run_q;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [IW-1:0]       inflight_count;
  logic [CW-1:0]       ofifo_count;
  logic                credit_ok;
  logic                accept;
  logic                retire;
  logic                push;
  logic                pop;
  logic                capture;
  ofifo_entry_t        push_data;
  ofifo_entry_t        head;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight_count = inflight_count + IW'(vld_sr[i]);
    end
  end

  // Every issued bit reserves a FIFO slot until it retires.
  assign credit_ok = (32'(ofifo_count) + 32'(inflight_count)) < 32'(OFIFO_DEPTH);
  assign accept    = in_valid && in_ready;
  assign rec_bit   = accept && in_bit;
  assign retire    = vld_sr[PIPE_LAT-1];
  assign push      = retire && (rec_btr != '0);
  assign push_data = '{bits: mask_bits(rec_ostream, rec_btr), len: rec_btr};
  assign pop       = out_valid && out_ready;
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rec_if    = 1'b0;
    msg_done  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = run_q && credit_ok;
        if (in_valid && run_q && credit_ok) begin
          rec_if    = 1'b1;
          state_nxt = in_last ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        in_ready = run_q && credit_ok;
        if (in_valid && run_q && credit_ok && in_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave once the last result is retiring now; final_state arrives with it.
        if (inflight_count == IW'(retire)) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        msg_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PHI or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      run_q     <= 1'b0;
      vld_sr    <= '0;
      msg_state <= '0;
    end else begin
      state     <= state_nxt;
      run_q     <= 1'b1;
      vld_sr[0] <= accept;
      for (int i = 1; i < PIPE_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (capture) msg_state <= rec_final;
    end
  end

  tans_ofifo #(.DEPTH(OFIFO_DEPTH)) u_ofifo (
    .PHI       (PHI),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (ofifo_count)
  );

  assign out_valid = (ofifo_count != '0);
  assign out_bits  = head.bits;
  assign out_len   = head.len;

endmodule

// File: tb/tb_tans_recoder_ctrl.sv
// Bench for tans_recoder_ctrl: a timed recoder model answers each accepted
// bit PIPE_LAT cycles later, and a queue scoreboard checks FIFO output order.
module tb_tans_recoder_ctrl;

  localparam int P = 3;
  localparam int D = 4;
  localparam int W = 5;
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_DRAIN = 2'd2;

  // ---------------- clock / reset ----------------
  logic PHI = 1'b0;
  logic RST_N;
  always #5 PHI = ~PHI;

  logic       in_valid, in_ready, in_bit, in_last;
  logic       rec_bit, rec_if;
  logic [1:0] rec_btr;
  logic [2:0] rec_ostream;
  logic [3:0] rec_final;
  logic       out_valid, out_ready;
  logic [2:0] out_bits;
  logic [1:0] out_len;
  logic       msg_done;
  logic [3:0] msg_state;
  logic [1:0] fsm_state;

  tans_recoder_ctrl #(.PIPE_LAT(P), .OFIFO_DEPTH(D)) dut (
    .PHI(PHI), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .rec_bit(rec_bit), .rec_if(rec_if),
    .rec_btr(rec_btr), .rec_ostream(rec_ostream), .rec_final(rec_final),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_len(out_len),
    .msg_done(msg_done), .msg_state(msg_state), .fsm_state(fsm_state)
  );

  int cyc = 0;
  always @(posedge PHI) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  bit in_msg   = 0;
  bit rand_ord = 0;

  typedef struct {
    int         due;
    logic [1:0] btr;
    logic [2:0] os;
  } res_t;
  res_t          pend_q[$];
  logic [W-1:0]  exp_q[$];

  // ---------------- recoder model + random downstream ----------------
  always @(posedge PHI) begin
    #1;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      rec_btr     = pend_q[0].btr;
      rec_ostream = pend_q[0].os;
      void'(pend_q.pop_front());
    end else begin
      rec_btr     = 2'($urandom_range(0, 3));
      rec_ostream = 3'($urandom);
    end
    if (rand_ord) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard ----------------
  always @(negedge PHI) begin
    logic [W-1:0] exp;
    if (RST_N === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        n_pops++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_entry got bits=%b len=%0d required no entry", out_bits, out_len);
        end else begin
          exp = exp_q.pop_front();
          if ({out_bits, out_len} !== exp) begin
            n_fail++;
            $display("FAIL sb_entry got bits=%b len=%0d required bits=%b len=%0d",
                     out_bits, out_len, exp[4:2], exp[1:0]);
          end
        end
      end
      if (!(in_valid === 1'b1 && in_ready === 1'b1)) begin
        n_checks++;
        if (rec_bit !== 1'b0 || rec_if !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_rec_outputs got rec_bit=%b rec_if=%b required 0 0", rec_bit, rec_if);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic record_accept(input logic b, input logic [1:0] btr, input logic [2:0] os);
    res_t r;
    r.due = cyc + P;
    r.btr = btr;
    r.os  = os;
    pend_q.push_back(r);
    if (btr != 2'd0) exp_q.push_back({3'(int'(os) & ((1 << btr) - 1)), btr});
  endtask

  task automatic pick(input int mode, output logic [1:0] btr, output logic [2:0] os);
    os = 3'($urandom);
    case (mode)
      0:       btr = 2'($urandom_range(0, 3));
      1:       btr = 2'd0;
      2:       btr = 2'($urandom_range(1, 3));
      default: begin btr = 2'd2; os = 3'b111; end
    endcase
  endtask

  task automatic drive_bit(input logic b, input logic last, input logic [1:0] btr,
                           input logic [2:0] os, output int acc_cyc);
    bit acc = 0;
    acc_cyc  = -1;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge PHI);
      if (in_ready === 1'b1) begin
        acc = 1;
        n_checks++;
        if (rec_if !== !in_msg || rec_bit !== b) begin
          n_fail++;
          $display("FAIL accept_path got rec_if=%b rec_bit=%b required rec_if=%b rec_bit=%b",
                   rec_if, rec_bit, !in_msg, b);
        end
        acc_cyc = cyc;
        record_accept(b, btr, os);
        in_msg = !last;
      end
      @(posedge PHI); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    in_bit   = 1'($urandom);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout got no accept in 100 cycles required an accept");
    end
  endtask

  task automatic send_msg(input int nbits, input logic [7:0] bits_v, input int mode,
                          input bit do_last, input bit gaps,
                          output int acc_cyc, output logic [3:0] fin);
    logic [1:0] btr;
    logic [2:0] os;
    @(posedge PHI); #1;
    fin       = 4'($urandom_range(1, 15));
    rec_final = fin;
    for (int i = 0; i < nbits; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge PHI); #1; end
      pick(mode, btr, os);
      drive_bit(bits_v[i], do_last && (i == nbits - 1), btr, os, acc_cyc);
    end
  endtask

  task automatic wait_done(input int acc_cyc, input logic [3:0] fin);
    bit seen = 0;
    int dcyc = -1;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge PHI);
      if (msg_done === 1'b1) begin seen = 1; dcyc = cyc; end
    end
    n_checks++;
    if (!seen || dcyc != acc_cyc + P + 1) begin
      n_fail++;
      $display("FAIL msg_done_latency got seen=%0d delay=%0d required delay=%0d",
               seen, dcyc - acc_cyc, P + 1);
    end
    n_checks++;
    if (msg_state !== fin) begin
      n_fail++;
      $display("FAIL msg_state got %h required %h", msg_state, fin);
    end
    rec_final = ~fin;
    @(negedge PHI);
    n_checks++;
    if (msg_done !== 1'b0 || msg_state !== fin) begin
      n_fail++;
      $display("FAIL msg_done_pulse got msg_done=%b msg_state=%h required 0 %h", msg_done, msg_state, fin);
    end
  endtask

  task automatic drain_fifo();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge PHI);
    @(negedge PHI);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain got pending=%0d out_valid=%b required 0 0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; rec_final = 4'd0;
    repeat (2) @(posedge PHI);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || msg_done !== 1'b0 ||
        msg_state !== 4'd0 || fsm_state !== ENC_IDLE) begin
      n_fail++;
      $display("FAIL reset_values got in_ready=%b out_valid=%b msg_done=%b msg_state=%h fsm=%0d required 0 0 0 0 0",
               in_ready, out_valid, msg_done, msg_state, fsm_state);
    end
    @(negedge PHI);
    RST_N = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge got %b required 0", in_ready);
    end
    @(posedge PHI); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic_msg();
    int acc; logic [3:0] fin;
    out_ready = 1'b1;
    send_msg(3, 8'b0000_0001, 0, 1, 0, acc, fin);
    wait_done(acc, fin);
  endtask

  task automatic test_fixed_result();
    int acc; logic [3:0] fin;
    out_ready = 1'b0;
    send_msg(1, 8'($urandom), 3, 1, 0, acc, fin);
    wait_done(acc, fin);
    n_checks++;
    if (out_valid !== 1'b1 || out_bits !== 3'b011 || out_len !== 2'd2) begin
      n_fail++;
      $display("FAIL fixed_head got valid=%b bits=%b len=%0d required 1 011 2", out_valid, out_bits, out_len);
    end
    @(posedge PHI); #1;
    out_ready = 1'b1;
    drain_fifo();
  endtask

  task automatic test_zero_btr();
    int acc; logic [3:0] fin; int pops0;
    out_ready = 1'b1;
    pops0 = n_pops;
    send_msg(5, 8'($urandom), 1, 1, 1, acc, fin);
    wait_done(acc, fin);
    n_checks++;
    if (n_pops != pops0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_btr got pops=%0d out_valid=%b required 0 0", n_pops - pops0, out_valid);
    end
  endtask

  task automatic test_single_bit();
    int acc; logic [3:0] fin; logic [1:0] btr; logic [2:0] os;
    @(posedge PHI); #1;
    fin = 4'($urandom_range(1, 15));
    rec_final = fin;
    pick(0, btr, os);
    drive_bit(1'($urandom), 1'b1, btr, os, acc);
    n_checks++;
    if (fsm_state !== ENC_DRAIN) begin
      n_fail++;
      $display("FAIL single_bit_state got %0d required %0d", fsm_state, ENC_DRAIN);
    end
    wait_done(acc, fin);
  endtask

  task automatic test_backpressure();
    int n_acc = 0; int acc; logic [3:0] fin; logic b; logic [1:0] btr; logic [2:0] os;
    out_ready = 1'b0;
    @(posedge PHI); #1;
    b = 1'($urandom);
    pick(2, btr, os);
    in_valid = 1'b1; in_bit = b; in_last = 1'b0;
    for (int t = 0; t < D + P + 6; t++) begin
      @(negedge PHI);
      if (in_ready === 1'b1) begin
        n_acc++;
        record_accept(b, btr, os);
        in_msg = 1;
        @(posedge PHI); #1;
        b = 1'($urandom);
        pick(2, btr, os);
        in_bit = b;
      end else begin
        @(posedge PHI); #1;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_acc != D) begin
      n_fail++;
      $display("FAIL backpressure_accepts got %0d required %0d", n_acc, D);
    end
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_stall got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    drain_fifo();
    send_msg(1, 8'($urandom), 0, 1, 0, acc, fin);
    wait_done(acc, fin);
  endtask

  task automatic test_reset_midmsg();
    int acc; logic [3:0] fin; logic [1:0] btr; logic [2:0] os;
    out_ready = 1'b0;
    @(posedge PHI); #1;
    for (int i = 0; i < 4; i++) begin
      pick(2, btr, os);
      drive_bit(1'($urandom), 1'b0, btr, os, acc);
    end
    @(posedge PHI); #1;
    @(negedge PHI);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_fifo got out_valid=%b required 1", out_valid);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || msg_done !== 1'b0 ||
        msg_state !== 4'd0 || fsm_state !== ENC_IDLE) begin
      n_fail++;
      $display("FAIL midmsg_reset got in_ready=%b out_valid=%b msg_done=%b msg_state=%h fsm=%0d required 0 0 0 0 0",
               in_ready, out_valid, msg_done, msg_state, fsm_state);
    end
    pend_q.delete();
    exp_q.delete();
    in_msg = 0;
    @(posedge PHI);
    @(negedge PHI);
    RST_N = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_midreset got %b required 0", in_ready);
    end
    out_ready = 1'b1;
    send_msg(2, 8'($urandom), 0, 1, 0, acc, fin);
    wait_done(acc, fin);
  endtask

  task automatic test_random_msgs();
    int acc; logic [3:0] fin;
    rand_ord = 1;
    for (int m = 0; m < 10; m++) begin
      send_msg($urandom_range(1, 8), 8'($urandom), 0, 1, 1, acc, fin);
      wait_done(acc, fin);
    end
    rand_ord = 0;
    @(posedge PHI); #2;
    out_ready = 1'b1;
    drain_fifo();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_msg();
    test_fixed_result();
    test_zero_btr();
    test_single_bit();
    test_backpressure();
    test_reset_midmsg();
    test_random_msgs();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
